// File: rtl/slv_rst_ctrl.sv
// Subordinate reset sequencer: isolate the bus, drain (with timeout), pulse the active-low
// subordinate reset, wait for settle, then acknowledge back to the slave guard.
module slv_rst_ctrl #(
    parameter int unsigned HoldCycles   = 16,
    parameter int unsigned SettleCycles = 8,
    parameter int unsigned DrainTimeout = 256,
    parameter int unsigned CntWidth     = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rst_req_i,
    input  logic       bus_idle_i,
    input  logic       clr_i,
    output logic       rst_stat_o,
    output logic       slv_rst_no,
    output logic       iso_o,
    output logic       drain_to_o,
    output logic [7:0] rst_cnt_o
);

    localparam longint unsigned CntLimit = longint'(1) << CntWidth;

    if (HoldCycles < 1 || longint'(HoldCycles) >= CntLimit) begin : gen_bad_hold
        $error("HoldCycles must be >= 1 and fit in CntWidth bits");
    end
    if (SettleCycles < 1 || longint'(SettleCycles) >= CntLimit) begin : gen_bad_settle
        $error("SettleCycles must be >= 1 and fit in CntWidth bits");
    end
    if (DrainTimeout < 1 || longint'(DrainTimeout) >= CntLimit) begin : gen_bad_drain
        $error("DrainTimeout must be >= 1 and fit in CntWidth bits");
    end

    localparam logic [CntWidth-1:0] HoldMax   = CntWidth'(HoldCycles - 1);
    localparam logic [CntWidth-1:0] SettleMax = CntWidth'(SettleCycles - 1);
    localparam logic [CntWidth-1:0] DrainMax  = CntWidth'(DrainTimeout - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIsolate,
        StAssert,
        StRelease,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                drain_to_q, drain_to_d;
    logic [7:0]          rst_cnt_q, rst_cnt_d;
    logic                iso_q, iso_d;
    logic                slv_rst_n_q, slv_rst_n_d;
    logic                stat_q, stat_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_to_d = drain_to_q;
        rst_cnt_d  = rst_cnt_q;

        // Clear first so a same-cycle timeout below overrides it.
        if (clr_i) drain_to_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (rst_req_i) begin
                    state_d = StIsolate;
                    cnt_d   = '0;
                end
            end
            StIsolate: begin
                if (bus_idle_i) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                end else if (cnt_q == DrainMax) begin
                    state_d    = StAssert;
                    cnt_d      = '0;
                    drain_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StAssert: begin
                if (cnt_q == HoldMax) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StRelease: begin
                if (cnt_q == SettleMax) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    if (rst_cnt_q != 8'hFF) rst_cnt_d = rst_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StDone: begin
                if (!rst_req_i) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, keeping slv_rst_no glitch-free.
    always_comb begin
        iso_d       = (state_d == StIsolate) || (state_d == StAssert) || (state_d == StRelease);
        slv_rst_n_d = (state_d != StAssert);
        stat_d      = (state_d == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            drain_to_q  <= 1'b0;
            rst_cnt_q   <= 8'd0;
            iso_q       <= 1'b0;
            slv_rst_n_q <= 1'b1;
            stat_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_to_q  <= drain_to_d;
            rst_cnt_q   <= rst_cnt_d;
            iso_q       <= iso_d;
            slv_rst_n_q <= slv_rst_n_d;
            stat_q      <= stat_d;
        end
    end

    assign rst_stat_o = stat_q;
    assign slv_rst_no = slv_rst_n_q;
    assign iso_o      = iso_q;
    assign drain_to_o = drain_to_q;
    assign rst_cnt_o  = rst_cnt_q;

endmodule

// File: tb/tb_slv_rst_ctrl.sv
// Directed self-checking bench for slv_rst_ctrl with default parameters.
module tb_slv_rst_ctrl;

    localparam int H  = 16;
    localparam int S  = 8;
    localparam int DT = 256;
    localparam int NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rst_req_i = 1'b0;
    logic       bus_idle_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       rst_stat_o;
    logic       slv_rst_no;
    logic       iso_o;
    logic       drain_to_o;
    logic [7:0] rst_cnt_o;

    int checks = 0;
    int errors = 0;

    slv_rst_ctrl #(
        .HoldCycles  (H),
        .SettleCycles(S),
        .DrainTimeout(DT),
        .CntWidth    (16)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .rst_req_i (rst_req_i),
        .bus_idle_i(bus_idle_i),
        .clr_i     (clr_i),
        .rst_stat_o(rst_stat_o),
        .slv_rst_no(slv_rst_no),
        .iso_o     (iso_o),
        .drain_to_o(drain_to_o),
        .rst_cnt_o (rst_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raise rst_req_i just before edge 0; bus_idle_i is 1 at edge k iff k >= d.
    // Returns first edge with slv_rst_no low, number of low cycles, first edge with
    // rst_stat_o high (-1 on budget expiry), and iso_o right after edge 0.
    task automatic do_seq(input int d, input int drop_at, output int fall, output int low,
                          output int lat, output logic iso0);
        fall = -1;
        low  = 0;
        lat  = -1;
        iso0 = 1'b0;
        rst_req_i  = 1'b1;
        bus_idle_i = (d == 0);
        for (int k = 0; k < 2000 && lat < 0; k++) begin
            tick();
            if (k == 0) iso0 = iso_o;
            if (slv_rst_no == 1'b0) begin
                low++;
                if (fall < 0) fall = k;
            end
            if (rst_stat_o == 1'b1) lat = k;
            if (k + 1 >= d) bus_idle_i = 1'b1;
            if (k == drop_at) rst_req_i = 1'b0;
        end
    endtask

    int   fall, low, lat;
    logic iso0;
    logic all_stat, all_rel;

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_state_stat", rst_stat_o, 0);
        chk("rst_slv_rst_no", slv_rst_no, 1);
        chk("rst_iso", iso_o, 0);
        chk("rst_drain_to", drain_to_o, 0);
        chk("rst_cnt", rst_cnt_o, 0);
        rst_i = 1'b0;
        tick();
        chk("idle_iso", iso_o, 0);

        // Basic sequence, bus already idle
        do_seq(0, -1, fall, low, lat, iso0);
        chk("basic_iso_edge0", iso0, 1);
        chk("basic_fall", fall, 1);
        chk("basic_low", low, H);
        chk("basic_lat", lat, 1 + H + S);
        chk("basic_iso_done", iso_o, 0);
        chk("basic_cnt", rst_cnt_o, 1);
        chk("basic_drain_to", drain_to_o, 0);

        // Handshake: request held in DONE does not retrigger
        all_stat = 1'b1;
        all_rel  = 1'b1;
        repeat (5) begin
            tick();
            all_stat &= rst_stat_o;
            all_rel  &= slv_rst_no;
        end
        chk("hold_stat", all_stat, 1);
        chk("hold_no_reset", all_rel, 1);
        chk("hold_cnt", rst_cnt_o, 1);
        rst_req_i = 1'b0;
        tick();
        chk("drop_stat", rst_stat_o, 0);

        // Drain wait: bus busy for 10 ISOLATE cycles
        do_seq(11, -1, fall, low, lat, iso0);
        chk("drain_fall", fall, 11);
        chk("drain_low", low, H);
        chk("drain_lat", lat, 11 + H + S);
        chk("drain_to_clear", drain_to_o, 0);
        chk("drain_cnt", rst_cnt_o, 2);
        rst_req_i = 1'b0;
        tick();

        // Timeout: bus never idle
        do_seq(NEVER, -1, fall, low, lat, iso0);
        chk("to_fall", fall, DT);
        chk("to_low", low, H);
        chk("to_lat", lat, DT + H + S);
        chk("to_drain_set", drain_to_o, 1);
        chk("to_cnt", rst_cnt_o, 3);
        rst_req_i = 1'b0;
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("clr_drain", drain_to_o, 0);

        // Request dropped during ASSERT: sequence completes, one-cycle ack
        do_seq(0, 5, fall, low, lat, iso0);
        chk("mid_low", low, H);
        chk("mid_lat", lat, 1 + H + S);
        tick();
        chk("mid_stat_pulse", rst_stat_o, 0);
        chk("mid_cnt", rst_cnt_o, 4);

        // Synchronous reset during ASSERT
        rst_req_i  = 1'b1;
        bus_idle_i = 1'b1;
        repeat (3) tick();
        chk("pre_rst_assert", slv_rst_no, 0);
        rst_i = 1'b1;
        tick();
        chk("midrst_slv_rst_no", slv_rst_no, 1);
        chk("midrst_iso", iso_o, 0);
        chk("midrst_cnt", rst_cnt_o, 0);
        rst_i     = 1'b0;
        rst_req_i = 1'b0;
        tick();

        // Saturation of the completed-sequence counter
        for (int i = 0; i < 260; i++) begin
            do_seq(0, -1, fall, low, lat, iso0);
            rst_req_i = 1'b0;
            tick();
            if (i == 253) chk("sat_254", rst_cnt_o, 254);
            if (i == 254) chk("sat_255", rst_cnt_o, 255);
        end
        chk("sat_final", rst_cnt_o, 255);

        // Timeout and clr_i in the same cycle: set wins
        rst_req_i  = 1'b1;
        bus_idle_i = 1'b0;
        clr_i      = 1'b1;
        repeat (DT) tick();
        chk("setwin_before", drain_to_o, 0);
        tick();
        chk("setwin_drain", drain_to_o, 1);
        chk("setwin_assert", slv_rst_no, 0);
        tick();
        chk("setwin_clr_after", drain_to_o, 0);
        clr_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
